// File: rtl/key_pio_pkg.sv
// Shared constants for the key input PIO: register addresses and edge-select encodings.
package key_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Picks the edge pulse this instance is configured to latch.
  function automatic logic edge_hit(input logic rise, input logic fall, input edge_type_e sel);
    logic hit;
    case (sel)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      default:   hit = rise | fall;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/key_pio_in_if.sv
// Avalon-MM slave bus bundle for the key input PIO, including its level interrupt.
interface key_pio_in_if #(
  parameter int WIDTH = 4
);

  logic [1:0]       address;
  logic             chipselect;
  logic             read_n;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;
  logic             irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/key_debounce.sv
// One input pin: two-flop synchronizer followed by a stability counter.
// The counter exists only when KEY_PIO_DEBOUNCE_EN is defined; otherwise the synchronizer output is passed straight through.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = pin;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Any sample that agrees with the accepted level restarts the count, so glitches never accumulate.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
`else
  assign stable = s2_q;
`endif

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce_cycles
    $error("key_debounce: DEBOUNCE_CYCLES must lie in 2 .. 2**20");
  end

endmodule

// File: rtl/key_pio_in.sv
// Key input PIO: per-pin sync/debounce, per-bit edge capture (W1C), maskable registered irq.
// Optional debounce filter is enabled with the KEY_PIO_DEBOUNCE_EN macro.
module key_pio_in
  import key_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  key_pio_in_if.slave      bus,
  input  logic [WIDTH-1:0] in_port
);

  localparam edge_type_e EDGE_SEL = (EDGE_TYPE == 0) ? EDGE_RISE :
                                    (EDGE_TYPE == 2) ? EDGE_ANY  : EDGE_FALL;

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise, fall, edge_pulse;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] w1c_clear;
  logic             rd_en, wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (reset),
      .pin   (in_port[i]),
      .stable(stable[i])
    );
  end

  assign rd_en = bus.chipselect & ~bus.read_n;
  assign wr_en = bus.chipselect & ~bus.write_n;

  always_comb begin
    rise = stable & ~prev_q;
    fall = ~stable & prev_q;
    for (int i = 0; i < WIDTH; i++) begin
      edge_pulse[i] = edge_hit(rise[i], fall[i], EDGE_SEL);
    end
  end

  always_comb begin
    prev_d     = stable;
    irq_mask_d = irq_mask_q;
    w1c_clear  = '0;
    if (wr_en && bus.address == ADDR_MASK) begin
      irq_mask_d = bus.writedata;
    end
    if (wr_en && bus.address == ADDR_EDGE) begin
      w1c_clear = bus.writedata;
    end
    // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
    edge_capture_d = (edge_capture_q & ~w1c_clear) | edge_pulse;
    irq_d          = |(edge_capture_q & irq_mask_q);
  end

  // Read data samples the registers before this edge updates them.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (bus.address)
        ADDR_DATA: readdata_d = stable;
        ADDR_MASK: readdata_d = irq_mask_q;
        ADDR_EDGE: readdata_d = edge_capture_q;
        default:   readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
      irq_q          <= 1'b0;
    end else begin
      prev_q         <= prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
      irq_q          <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_key_pio_in.sv
// Directed bench for key_pio_in (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=falling).
module tb_key_pio_in;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;
`ifdef KEY_PIO_DEBOUNCE_EN
  localparam int  LAT        = 2 + DEB;
  localparam bit  FILTERED   = 1'b1;
`else
  localparam int  LAT        = 2;
  localparam bit  FILTERED   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_port;
  logic [WIDTH-1:0] rd;
  int               n_checks = 0;
  int               n_errors = 0;

  key_pio_in_if #(.WIDTH(WIDTH)) bus ();

  key_pio_in #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .EDGE_TYPE      (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .in_port(in_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with readdata sampled.
  task automatic bus_read(input logic [1:0] addr, output logic [WIDTH-1:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    data           = bus.readdata;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset          = 1'b1;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    idle(3);
    reset = 1'b0;

    chk("rst_readdata", bus.readdata, 0);
    chk("rst_irq", bus.irq, 0);
    bus_read(2'd0, rd); chk("rst_data", rd, 0);
    bus_read(2'd2, rd); chk("rst_mask", rd, 0);
    bus_read(2'd3, rd); chk("rst_edge", rd, 0);

    // Pins held high through reset come in as a rising edge, which is not captured.
    idle(LAT + 2);
    bus_read(2'd0, rd); chk("settle_data", rd, 4'hF);
    bus_read(2'd3, rd); chk("settle_edge", rd, 0);

    // Bit 0 falls; a read on the accepting edge still sees the old value.
    in_port = 4'hE;
    idle(LAT - 1);
    bus_read(2'd0, rd); chk("fall_pre", rd, 4'hF);
    bus_read(2'd0, rd); chk("fall_data", rd, 4'hE);
    bus_read(2'd3, rd); chk("fall_edge", rd, 4'h1);
    chk("fall_irq_masked", bus.irq, 0);

    bus_write(2'd2, 4'h1);
    chk("mask_irq_same", bus.irq, 0);
    idle(1);
    chk("mask_irq_rise", bus.irq, 1);
    bus_read(2'd2, rd); chk("mask_read", rd, 4'h1);

    bus_write(2'd3, 4'h1);
    chk("w1c_irq_same", bus.irq, 1);
    idle(1);
    chk("w1c_irq_fall", bus.irq, 0);
    bus_read(2'd3, rd); chk("w1c_edge", rd, 0);

    // Three-cycle low pulse on bit 1: rejected by the filter, passed without it.
    in_port = 4'hC;
    idle(3);
    in_port = 4'hE;
    idle(LAT + 4);
    bus_read(2'd0, rd); chk("glitch_data", rd, 4'hE);
    bus_read(2'd3, rd); chk("glitch_edge", rd, FILTERED ? 4'h0 : 4'h2);
    bus_write(2'd3, 4'hF);
    bus_read(2'd3, rd); chk("glitch_clear", rd, 0);

    // W1C lands on the same edge that latches the bit 1 fall.
    in_port = 4'hC;
    idle(LAT);
    bus_write(2'd3, 4'h2);
    bus_read(2'd3, rd); chk("set_wins_edge", rd, 4'h2);
    bus_read(2'd0, rd); chk("set_wins_data", rd, 4'hC);
    bus_write(2'd3, 4'hF);
    bus_read(2'd3, rd); chk("set_wins_clear", rd, 0);

    // Bit 2 falls, reset lands two cycles into its debounce window.
    in_port = 4'h8;
    idle(4);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("mid_rst_readdata", bus.readdata, 0);
    chk("mid_rst_irq", bus.irq, 0);
    bus_read(2'd3, rd); chk("mid_rst_edge0", rd, 0);
    idle(LAT + 3);
    bus_read(2'd0, rd); chk("mid_rst_data", rd, 4'h8);
    bus_read(2'd3, rd); chk("mid_rst_edge", rd, 0);
    bus_read(2'd2, rd); chk("mid_rst_mask", rd, 0);
    chk("mid_rst_irq_end", bus.irq, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_pio_in.md
Name: key_pio_in

Overview:
- Avalon-MM slave input port: the read-side counterpart of the write-only output PIO slaves that drive LCD and control lines.
- Samples WIDTH asynchronous pins, such as front-panel keys.
- Synchronizes and debounces each pin, captures edges per bit and raises a maskable level interrupt to the Nios CPU.
- Sits on the system interconnect next to the output PIOs; the CPU polls it or services its irq.

Parameters:
- WIDTH, 4, number of input pins and data-bus width.
- DEBOUNCE_CYCLES, 50000, clk cycles an input must stay stable before it is accepted (1 ms at 50 MHz); legal range 2 to 2^20.
- EDGE_TYPE, 1, edge to capture: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- read_n  in  1  active-low read strobe.
- write_n  in  1  active-low write strobe.
- writedata  in  WIDTH  write data.
- readdata  out  WIDTH  registered read data.
- irq  out  1  level interrupt, active-high.
- in_port  in  WIDTH  asynchronous input pins.

Behaviour:
- Reset is synchronous, active-high and sampled on posedge clk; it overrides everything. On reset:
  - sync flops, stable state and last state are cleared to 0;
  - debounce counters, irq_mask and edge_capture are cleared to 0;
  - readdata = 0 and irq = 0.
- Synchronizer: two flops per bit. Output is s[i], 2 cycles of latency from the pin.
- Debounce, per bit, with counter width clog2(DEBOUNCE_CYCLES):
  - if s[i] equals stable[i], cnt[i] is cleared to 0;
  - otherwise cnt[i] increments;
  - when cnt[i] reaches DEBOUNCE_CYCLES-1 while s[i] still differs, stable[i] takes s[i] and cnt[i] is cleared;
  - any glitch back to stable[i] restarts the count;
  - total pin-to-stable latency is 2 + DEBOUNCE_CYCLES cycles.
- Edge detect, per bit:
  - prev[i] is stable[i] delayed by one cycle;
  - rise = stable & ~prev; fall = ~stable & prev;
  - the pulse selected by EDGE_TYPE sets edge_capture[i].
- Register map, qualified by chipselect:
  - address 0: data. Reads return stable; writes are ignored.
  - address 1: reserved. Reads return 0; writes are ignored.
  - address 2: irq_mask. Read/write.
  - address 3: edge_capture. Read; a write clears each bit whose writedata bit is 1 (write-1-to-clear).
- Read timing: on a cycle with chipselect & ~read_n, readdata is registered from the addressed register. Read latency is 1 cycle, with no wait states. readdata holds its value between reads.
- A write to irq_mask takes effect the next cycle.
- irq is registered: irq = |(edge_capture & irq_mask). It updates 1 cycle after either operand changes.
- Simultaneous events:
  - if an edge set and a W1C clear hit the same bit in the same cycle, the set wins and the bit stays 1;
  - a data read in the same cycle that stable changes returns the pre-change value.
- If read_n and write_n are both low, both actions are performed.
- Reset mid-debounce discards any pending transition. After reset, a pin held at 1 is accepted as a rising transition after 2 + DEBOUNCE_CYCLES cycles.

Optional Feature:
- Macro: KEY_PIO_DEBOUNCE_EN.
- Defined: the debounce filter is built as described above.
- Undefined: no counters are instantiated; stable = s directly; pin-to-stable latency is 2 cycles; the DEBOUNCE_CYCLES parameter is ignored.

Decomposition:
- Package key_pio_pkg holds:
  - address constants ADDR_DATA = 2'd0, ADDR_MASK = 2'd2, ADDR_EDGE = 2'd3;
  - EDGE_TYPE encodings EDGE_RISE, EDGE_FALL, EDGE_ANY.
- One sub-module, key_debounce: a single-bit synchronizer plus debounce counter, instantiated WIDTH times in a generate loop.
- Edge detection and the register file stay in the top module.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1):
- Reset, then read addresses 0, 2 and 3 -> readdata = 0 each time, with 1-cycle latency; irq = 0.
- Drive in_port from 4'hF to 4'hE (bit 0 falls) -> data reads 4'hE exactly 6 cycles after the pin change; edge_capture = 4'h1; irq stays 0 while irq_mask = 0.
- Write irq_mask = 4'h1 -> irq rises on the next cycle. Write 4'h1 to address 3 -> edge_capture = 0 and irq falls on the following cycle.
- Toggle bit 1 low for 3 cycles, then back high -> stable is unchanged; edge_capture bit 1 stays 0 (glitch rejected).
- Apply a W1C of 4'h2 in the exact cycle a bit 1 falling edge is detected -> edge_capture bit 1 = 1 (set wins).
- Assert reset while a bit 2 transition is 2 cycles into debounce -> all state is 0 afterwards; with the pin held at 0, no falling edge is captured.
